// File: rtl/fb_access_arbiter_if.sv
// Bus bundle between the CPU/display requesters, the framebuffer RAM and fb_access_arbiter.
// slave: the arbiter's view. master: the requester/RAM environment's view.
interface fb_access_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cpu_wr_req;
  logic              cpu_rd_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_underrun;
  logic              disp_clr;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport slave (
    input  cpu_wr_req, cpu_rd_req, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  disp_req, disp_addr, disp_clr,
    output disp_valid, disp_data, disp_underrun,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output cpu_wr_req, cpu_rd_req, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output disp_req, disp_addr, disp_clr,
    input  disp_valid, disp_data, disp_underrun,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer RAM arbiter between CPU word accesses and display line fetches.
// Optional macro FBARB_FAIR_EN: CPU and display alternate when both are waiting.
module fb_access_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1   // legal 1..3
) (
  input  logic                 clk,
  input  logic                 rst,
  fb_access_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DISP} owner_t;

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              underrun_q, underrun_d;

  logic              idle;
  logic              cpu_ack_c;
  logic              cpu_req_vis;
  logic              grant_disp;
  logic              grant_cpu;

  assign idle      = (state_q == IDLE);
  assign cpu_ack_c = ((state_q == ACCESS) && is_wr_q) ||
                     ((state_q == RESP) && (owner_q == OWN_CPU));

  // A held request is invisible during its own ack cycle so it is never granted twice.
  assign cpu_req_vis = (bus.cpu_wr_req || bus.cpu_rd_req) && !cpu_ack_c;

`ifdef FBARB_FAIR_EN
  logic last_disp_q, last_disp_d;

  assign grant_disp = idle && pend_q && !(last_disp_q && cpu_req_vis);

  always_comb begin
    last_disp_d = last_disp_q;
    if (grant_disp) begin
      last_disp_d = 1'b1;
    end else if (grant_cpu) begin
      last_disp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_disp_q <= 1'b0;
    end else begin
      last_disp_q <= last_disp_d;
    end
  end
`else
  assign grant_disp = idle && pend_q;
`endif

  assign grant_cpu = idle && cpu_req_vis && !grant_disp;

  // Display pending slot: a new pulse always wins; overwriting an ungranted slot is an underrun.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    underrun_d  = underrun_q;
    if (grant_disp) begin
      pend_d = 1'b0;
    end
    if (bus.disp_clr) begin
      underrun_d = 1'b0;
    end
    if (bus.disp_req) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.disp_addr;
      if (pend_q && !grant_disp) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    lat_cnt_d   = lat_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    disp_data_d = disp_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_disp) begin
          owner_d    = OWN_DISP;
          is_wr_d    = 1'b0;
          ram_addr_d = pend_addr_q;
          state_d    = ACCESS;
        end else if (grant_cpu) begin
          owner_d    = OWN_CPU;
          is_wr_d    = bus.cpu_wr_req;
          ram_addr_d = bus.cpu_addr;
          if (bus.cpu_wr_req) begin
            ram_wdata_d = bus.cpu_wdata;
          end
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        lat_cnt_d = 2'd0;
        state_d   = is_wr_q ? IDLE : WAIT;
      end

      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.ram_rdata;
          end else begin
            disp_data_d = bus.ram_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      is_wr_q     <= 1'b0;
      lat_cnt_q   <= 2'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      disp_data_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      lat_cnt_q   <= lat_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      disp_data_q <= disp_data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.cpu_ack       = cpu_ack_c;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.disp_valid    = (state_q == RESP) && (owner_q == OWN_DISP);
  assign bus.disp_data     = disp_data_q;
  assign bus.disp_underrun = underrun_q;
  assign bus.ram_en        = (state_q == ACCESS);
  assign bus.ram_we        = (state_q == ACCESS) && is_wr_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.busy          = !idle;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Testbench for fb_access_arbiter: table-driven CPU vectors, directed corner sequences,
// and randomized traffic checked against a word-level memory model.
module tb_fb_access_arbiter;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int RAM_LAT = 1;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM environment with RAM_LAT cycles of read latency.
  logic [31:0] ram_mem [16];
  logic [31:0] rd_pipe [3];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en) rd_pipe[0] <= ram_mem[bus.ram_addr];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.ram_rdata = rd_pipe[RAM_LAT-1];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [16];
  logic [3:0]  grant_q [$];
  int          n_valid, n_ack;
  logic [31:0] last_dd, last_cd;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010101;
  endfunction

  function automatic logic [3:0] grant_at(input int k);
    return (k < grant_q.size()) ? grant_q[k] : 4'hx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one CPU request from an IDLE cycle, hold it until ack, then return to IDLE.
  task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rdata,
                               output logic ram_ok);
    bus.cpu_wr_req = v.wr;
    bus.cpu_rd_req = v.rd;
    bus.cpu_addr   = v.addr;
    bus.cpu_wdata  = v.wdata;
    lat    = 0;
    ram_ok = 1'b1;
    do begin
      tick();
      lat++;
      if (bus.ram_en)
        ram_ok &= (bus.ram_addr == v.addr) && (bus.ram_we == v.wr) &&
                  (!v.wr || bus.ram_wdata == v.wdata);
    end while (!bus.cpu_ack && lat < 20);
    rdata = bus.cpu_rdata;
    bus.cpu_wr_req = 1'b0;
    bus.cpu_rd_req = 1'b0;
    tick();
  endtask

  task automatic observe(input int n, input bit drop_on_ack);
    grant_q.delete();
    n_valid = 0;
    n_ack   = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.ram_en) grant_q.push_back(bus.ram_addr);
      if (bus.disp_valid) begin
        n_valid++;
        last_dd = bus.disp_data;
      end
      if (bus.cpu_ack) begin
        n_ack++;
        last_cd = bus.cpu_rdata;
        if (drop_on_ack) begin
          bus.cpu_wr_req = 1'b0;
          bus.cpu_rd_req = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl [8];
    vec_t        v;
    int          lat;
    logic [31:0] rd;
    logic        ok;
    int          first_c, n_cpu, same_pairs;
    logic        first_we, got;

    rst = 1'b1;
    bus.cpu_wr_req = 1'b0; bus.cpu_rd_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.disp_req = 1'b0; bus.disp_addr = '0; bus.disp_clr = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 4'd5,  32'hDEADBEEF, 1,           32'h0};
    tbl[1] = '{1'b0, 1'b1, 4'd5,  32'h0,        2 + RAM_LAT, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 4'd0,  32'h00000000, 1,           32'h0};
    tbl[3] = '{1'b0, 1'b1, 4'd15, 32'h0,        2 + RAM_LAT, init_word(15)};
    tbl[4] = '{1'b1, 1'b0, 4'd15, 32'hFFFFFFFF, 1,           32'h0};
    tbl[5] = '{1'b0, 1'b1, 4'd15, 32'h0,        2 + RAM_LAT, 32'hFFFFFFFF};
    tbl[6] = '{1'b0, 1'b1, 4'd0,  32'h0,        2 + RAM_LAT, 32'h00000000};
    tbl[7] = '{1'b0, 1'b1, 4'd5,  32'h0,        2 + RAM_LAT, 32'hDEADBEEF};

    tick(); tick();
    checkOutput("rst_cpu_ack", bus.cpu_ack, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ram_en", bus.ram_en, 0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata, 0);
    checkOutput("rst_disp_data", bus.disp_data, 0);
    checkOutput("rst_underrun", bus.disp_underrun, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 1'b0, 4'(i), init_word(i), 1, 32'h0};
      applyStimulus(v, lat, rd, ok);
      checkOutput("preload_lat", lat, 1);
      checkOutput("preload_ram", ok, 1);
      model_mem[i] = init_word(i);
    end

    foreach (tbl[i]) begin
      applyStimulus(tbl[i], lat, rd, ok);
      checkOutput("vec_lat", lat, tbl[i].exp_lat);
      checkOutput("vec_ram", ok, 1);
      if (tbl[i].rd) checkOutput("vec_rdata", rd, tbl[i].exp_rdata);
      if (tbl[i].wr) model_mem[tbl[i].addr] = tbl[i].wdata;
    end

    // Collision: display pulse and CPU read both arrive in the ack cycle of a CPU write.
    bus.cpu_wr_req = 1'b1; bus.cpu_addr = 4'd0; bus.cpu_wdata = 32'h0BADF00D;
    tick();
    checkOutput("coll_wr_ack", bus.cpu_ack, 1);
    model_mem[0] = 32'h0BADF00D;
    bus.cpu_wr_req = 1'b0; bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd7;
    bus.disp_req = 1'b1; bus.disp_addr = 4'd2;
    tick();
    bus.disp_req = 1'b0;
    observe(15, 1'b1);
    checkOutput("coll_grants", grant_q.size(), 2);
    checkOutput("coll_first", grant_at(0), 4'd2);
    checkOutput("coll_second", grant_at(1), 4'd7);
    checkOutput("coll_nvalid", n_valid, 1);
    checkOutput("coll_disp_data", last_dd, model_mem[2]);
    checkOutput("coll_nack", n_ack, 1);
    checkOutput("coll_cpu_rdata", last_cd, model_mem[7]);
    checkOutput("coll_underrun", bus.disp_underrun, 0);

    // Underrun: first pulse lands during a CPU read WAIT, second overwrites it before grant.
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd6;
    tick(); tick();
    bus.disp_req = 1'b1; bus.disp_addr = 4'd1;
    tick();
    checkOutput("ur_read_ack", bus.cpu_ack, 1);
    checkOutput("ur_first_no_underrun", bus.disp_underrun, 0);
    bus.cpu_rd_req = 1'b0;
    bus.disp_addr = 4'd9;
    tick();
    bus.disp_req = 1'b0;
    checkOutput("ur_set", bus.disp_underrun, 1);
    observe(12, 1'b1);
    checkOutput("ur_grants", grant_q.size(), 1);
    checkOutput("ur_grant_addr", grant_at(0), 4'd9);
    checkOutput("ur_nvalid", n_valid, 1);
    checkOutput("ur_data", last_dd, model_mem[9]);
    bus.disp_clr = 1'b1;
    tick();
    bus.disp_clr = 1'b0;
    checkOutput("ur_clr", bus.disp_underrun, 0);
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd6;
    tick(); tick();
    bus.disp_req = 1'b1; bus.disp_addr = 4'd1;
    tick();
    bus.cpu_rd_req = 1'b0;
    bus.disp_addr = 4'd9; bus.disp_clr = 1'b1;
    tick();
    bus.disp_req = 1'b0; bus.disp_clr = 1'b0;
    checkOutput("ur_set_beats_clr", bus.disp_underrun, 1);
    observe(12, 1'b1);

    // Reset while a read sits in WAIT.
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd3;
    tick(); tick();
    checkOutput("rw_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rw_cpu_ack", bus.cpu_ack, 0);
    checkOutput("rw_cpu_rdata", bus.cpu_rdata, 0);
    checkOutput("rw_disp_valid", bus.disp_valid, 0);
    checkOutput("rw_disp_data", bus.disp_data, 0);
    checkOutput("rw_underrun", bus.disp_underrun, 0);
    checkOutput("rw_ram_en", bus.ram_en, 0);
    checkOutput("rw_ram_we", bus.ram_we, 0);
    checkOutput("rw_ram_addr", bus.ram_addr, 0);
    checkOutput("rw_ram_wdata", bus.ram_wdata, 0);
    checkOutput("rw_busy", bus.busy, 0);
    bus.cpu_rd_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    observe(6, 1'b1);
    checkOutput("rw_no_ack_after", n_ack, 0);
    checkOutput("rw_no_ram_after", grant_q.size(), 0);

    // Write and read requested together: write first, then the read sees the new word.
    bus.cpu_wr_req = 1'b1; bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd4; bus.cpu_wdata = 32'h12345678;
    n_ack = 0; first_c = 0; first_we = 1'b0; last_cd = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (bus.cpu_ack) begin
        n_ack++;
        if (n_ack == 1) begin
          first_c = c;
          first_we = bus.ram_we;
          bus.cpu_wr_req = 1'b0;
        end else begin
          last_cd = bus.cpu_rdata;
          bus.cpu_rd_req = 1'b0;
        end
      end
    end
    model_mem[4] = 32'h12345678;
    checkOutput("both_nack", n_ack, 2);
    checkOutput("both_first_cycle", first_c, 1);
    checkOutput("both_first_is_write", first_we, 1);
    checkOutput("both_rdata", last_cd, 32'h12345678);

    // Priority: display pulses every cycle while a CPU read is held.
    bus.disp_addr = 4'd8; bus.disp_req = 1'b1;
    tick();
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 4'd3;
    observe(40, 1'b0);
    n_cpu = 0; same_pairs = 0;
    foreach (grant_q[k]) begin
      if (grant_q[k] == 4'd3) n_cpu++;
      if (k > 0 && grant_q[k] == grant_q[k-1]) same_pairs++;
    end
    checkOutput("prio_enough_grants", grant_q.size() >= 6, 1);
`ifdef FBARB_FAIR_EN
    checkOutput("prio_alternate", same_pairs, 0);
    checkOutput("prio_cpu_served", n_cpu >= 3, 1);
    checkOutput("prio_cpu_acks", n_ack >= 3, 1);
`else
    checkOutput("prio_cpu_starved", n_cpu, 0);
    checkOutput("prio_cpu_no_ack", n_ack, 0);
`endif
    bus.disp_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (bus.cpu_ack) begin
        got = 1'b1;
        checkOutput("prio_cpu_rdata", bus.cpu_rdata, model_mem[3]);
      end
      tick();
    end
    checkOutput("prio_cpu_after_clear", got, 1);
    bus.cpu_rd_req = 1'b0;
    observe(8, 1'b1);
    bus.disp_clr = 1'b1;
    tick();
    bus.disp_clr = 1'b0;
    checkOutput("prio_clr", bus.disp_underrun, 0);

    // Randomized traffic against the word-level model: CPU writes 0..7, display reads 8..15.
    begin
      logic        cpu_out, disp_out, cur_wr, bad_underrun, bad_we;
      logic [3:0]  cur_a, disp_a;
      logic [31:0] cur_d;
      int          cpu_wait, disp_wait;
      cpu_out = 1'b0; disp_out = 1'b0; bad_underrun = 1'b0; bad_we = 1'b0;
      cpu_wait = 0; disp_wait = 0; cur_wr = 1'b0; cur_a = '0; cur_d = '0; disp_a = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (bus.cpu_ack) begin
          if (!cpu_out) checkOutput("rnd_unexpected_ack", 1, 0);
          else if (cur_wr) model_mem[cur_a] = cur_d;
          else checkOutput("rnd_cpu_rdata", bus.cpu_rdata, model_mem[cur_a]);
          cpu_out = 1'b0;
          bus.cpu_wr_req = 1'b0;
          bus.cpu_rd_req = 1'b0;
        end
        if (bus.disp_valid) begin
          if (!disp_out) checkOutput("rnd_unexpected_valid", 1, 0);
          else checkOutput("rnd_disp_data", bus.disp_data, model_mem[disp_a]);
          disp_out = 1'b0;
        end
        if (bus.disp_underrun) bad_underrun = 1'b1;
        if (bus.ram_we && !bus.ram_en) bad_we = 1'b1;
        cpu_wait  = cpu_out ? cpu_wait + 1 : 0;
        disp_wait = disp_out ? disp_wait + 1 : 0;
        if (cpu_wait > 40) begin
          checkOutput("rnd_cpu_timeout", cpu_wait, 40);
          cpu_out = 1'b0; bus.cpu_wr_req = 1'b0; bus.cpu_rd_req = 1'b0;
        end
        if (disp_wait > 40) begin
          checkOutput("rnd_disp_timeout", disp_wait, 40);
          disp_out = 1'b0;
        end
        if (!cpu_out && cyc < 1400 && $urandom_range(0, 2) == 0) begin
          cur_wr  = 1'($urandom_range(0, 1));
          cur_a   = cur_wr ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
          cur_d   = $urandom;
          cpu_out = 1'b1;
          bus.cpu_wr_req = cur_wr;
          bus.cpu_rd_req = !cur_wr;
          bus.cpu_addr   = cur_a;
          bus.cpu_wdata  = cur_d;
        end
        bus.disp_req = 1'b0;
        if (!disp_out && cyc < 1400 && $urandom_range(0, 3) == 0) begin
          disp_a = 4'($urandom_range(8, 15));
          disp_out = 1'b1;
          bus.disp_req  = 1'b1;
          bus.disp_addr = disp_a;
        end
        tick();
      end
      bus.disp_req = 1'b0;
      checkOutput("rnd_cpu_drained", cpu_out, 0);
      checkOutput("rnd_disp_drained", disp_out, 0);
      checkOutput("rnd_no_underrun", bad_underrun, 0);
      checkOutput("rnd_we_needs_en", bad_we, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
